// File: rtl/ddr_axi_arbiter.sv
// ddr_axi_arbiter
// Shares one DDR3 AXI user port between N_WR frame-writer channels and a
// single frame-reader channel. Runs one burst at a time. Reads win unless they
// have taken RD_STREAK grants in a row while a write is waiting. Writers are
// served round-robin.
//
// Ports
//   clk, rstn             DDR user clock, async active-low reset
//   wr_req/addr/len/data  per-writer request level, address, length-1, data
//   wr_grant/take/done    AW handshake pulse, W data-pop strobe, end pulse
//   rd_req/addr/len       reader request level, address, length-1
//   rd_grant              AR handshake pulse
//   rd_valid/last/data    returned read beat, registered
//   axi_aw*/w*/ar*/r*     controller-side AXI user port
//   busy                  high whenever a burst is in flight
module ddr_axi_arbiter #(
  parameter int unsigned N_WR      = 2,
  parameter int unsigned RD_STREAK = 4,
  parameter logic [3:0]  RD_ID     = 4'hF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_WR-1:0]       wr_req,
  input  logic [N_WR*28-1:0]    wr_addr,
  input  logic [N_WR*4-1:0]     wr_len,
  input  logic [N_WR*256-1:0]   wr_data,
  output logic [N_WR-1:0]       wr_grant,
  output logic [N_WR-1:0]       wr_take,
  output logic [N_WR-1:0]       wr_done,
  input  logic                  rd_req,
  input  logic [27:0]           rd_addr,
  input  logic [3:0]            rd_len,
  output logic                  rd_grant,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic [255:0]          rd_data,
  output logic [27:0]           axi_awaddr,
  output logic                  axi_awuser_ap,
  output logic [3:0]            axi_awuser_id,
  output logic [3:0]            axi_awlen,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [255:0]          axi_wdata,
  output logic [31:0]           axi_wstrb,
  input  logic                  axi_wready,
  input  logic                  axi_wusero_last,
  output logic [27:0]           axi_araddr,
  output logic                  axi_aruser_ap,
  output logic [3:0]            axi_aruser_id,
  output logic [3:0]            axi_arlen,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [255:0]          axi_rdata,
  input  logic [3:0]            axi_rid,
  input  logic                  axi_rlast,
  input  logic                  axi_rvalid,
  output logic                  busy
);

  localparam int unsigned IW = (N_WR > 1) ? $clog2(N_WR) : 1;
  localparam int unsigned SW = (RD_STREAK > 0) ? $clog2(RD_STREAK + 1) : 1;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   g_q, last_wr, pick, cand;
  logic            pick_ok, choose_rd;
  logic [SW-1:0]   streak;
  logic [27:0]     addr_q;
  logic [3:0]      len_q;
  logic [N_WR-1:0] wr_sel;
  logic            rid_unused;

  // Only one burst is ever outstanding, so the returned ID carries no information.
  assign rid_unused = ^axi_rid;

  // Round-robin search starting just after the last served writer.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= N_WR; i++) begin
      cand = IW'((32'(last_wr) + i) % N_WR);
      if (!pick_ok && wr_req[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  assign choose_rd = rd_req && ((streak < SW'(RD_STREAK)) || (wr_req == '0));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (choose_rd)    state_nx = RD_ADDR;
               else if (pick_ok) state_nx = WR_ADDR;
      RD_ADDR: if (axi_arready)  state_nx = RD_DATA;
      RD_DATA: if (axi_rvalid && axi_rlast) state_nx = IDLE;
      WR_ADDR: if (axi_awready)  state_nx = WR_DATA;
      WR_DATA: if (axi_wready && axi_wusero_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      g_q      <= '0;
      last_wr  <= IW'(N_WR - 1);
      streak   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      wr_done  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
    end else begin
      wr_done  <= (state == WR_DATA && axi_wready && axi_wusero_last) ? wr_sel : '0;
      rd_valid <= (state == RD_DATA) && axi_rvalid;
      rd_last  <= (state == RD_DATA) && axi_rvalid && axi_rlast;
      if (state == RD_DATA && axi_rvalid) rd_data <= axi_rdata;

      if (state == IDLE) begin
        if (choose_rd) begin
          addr_q <= rd_addr;
          len_q  <= rd_len;
        end else if (pick_ok) begin
          addr_q <= wr_addr[pick*28 +: 28];
          len_q  <= wr_len[pick*4 +: 4];
          g_q    <= pick;
        end
      end

      if (state == RD_ADDR && axi_arready && streak < SW'(RD_STREAK))
        streak <= streak + SW'(1);
      if (state == WR_ADDR && axi_awready) begin
        last_wr <= g_q;
        streak  <= '0;
      end
    end
  end

  always_comb begin
    wr_sel        = N_WR'(1) << g_q;
    axi_awvalid   = (state == WR_ADDR);
    axi_arvalid   = (state == RD_ADDR);
    busy          = (state != IDLE);
    wr_grant      = (axi_awvalid && axi_awready) ? wr_sel : '0;
    rd_grant      = axi_arvalid && axi_arready;
    wr_take       = (state == WR_DATA && axi_wready) ? wr_sel : '0;
    // Gated so the data bus reads zero outside a write burst (and in reset).
    axi_wdata     = (state == WR_DATA) ? wr_data[g_q*256 +: 256] : '0;
    axi_wstrb     = '1;
    axi_awaddr    = addr_q;
    axi_awlen     = len_q;
    axi_awuser_ap = 1'b0;
    axi_awuser_id = 4'(g_q);
    axi_araddr    = addr_q;
    axi_arlen     = len_q;
    axi_aruser_ap = 1'b0;
    axi_aruser_id = RD_ID;
  end

endmodule

// File: tb/tb_ddr_axi_arbiter.sv
// Self-checking bench for ddr_axi_arbiter: directed scenarios plus randomized
// traffic against a transaction-level arbitration model.
module tb_ddr_axi_arbiter;
  localparam int unsigned N_WR      = 2;
  localparam int unsigned RD_STREAK = 4;
  localparam logic [3:0]  RD_ID     = 4'hF;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [N_WR-1:0]     wr_req = '0;
  logic [N_WR*28-1:0]  wr_addr = '0;
  logic [N_WR*4-1:0]   wr_len = '0;
  logic [N_WR*256-1:0] wr_data = '0;
  logic [N_WR-1:0]     wr_grant, wr_take, wr_done;
  logic rd_req = 1'b0;
  logic [27:0] rd_addr = '0;
  logic [3:0]  rd_len = '0;
  logic rd_grant, rd_valid, rd_last;
  logic [255:0] rd_data;
  logic [27:0] axi_awaddr, axi_araddr;
  logic axi_awuser_ap, axi_aruser_ap, axi_awvalid, axi_arvalid;
  logic [3:0] axi_awuser_id, axi_awlen, axi_aruser_id, axi_arlen;
  logic axi_awready = 1'b0, axi_wready = 1'b0, axi_wusero_last = 1'b0, axi_arready = 1'b0;
  logic [255:0] axi_wdata;
  logic [31:0]  axi_wstrb;
  logic [255:0] axi_rdata = '0;
  logic [3:0]   axi_rid = '0;
  logic axi_rlast = 1'b0, axi_rvalid = 1'b0;
  logic busy;

  ddr_axi_arbiter #(.N_WR(N_WR), .RD_STREAK(RD_STREAK), .RD_ID(RD_ID)) dut (
    .clk(clk), .rstn(rstn),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data),
    .wr_grant(wr_grant), .wr_take(wr_take), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_grant(rd_grant), .rd_valid(rd_valid), .rd_last(rd_last), .rd_data(rd_data),
    .axi_awaddr(axi_awaddr), .axi_awuser_ap(axi_awuser_ap), .axi_awuser_id(axi_awuser_id),
    .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wready(axi_wready),
    .axi_wusero_last(axi_wusero_last),
    .axi_araddr(axi_araddr), .axi_aruser_ap(axi_aruser_ap), .axi_aruser_id(axi_aruser_id),
    .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rid(axi_rid), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int m_streak;  // reads granted in a row (saturating)
  int m_last;    // last writer served

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic rand_payload();
    for (int i = 0; i < N_WR; i++) begin
      wr_addr[i*28 +: 28] = 28'($urandom);
      wr_len[i*4 +: 4]    = 4'($urandom_range(0, 7));
      wr_data[i*256 +: 256] = rand256();
    end
    rd_addr = 28'($urandom);
    rd_len  = 4'($urandom_range(0, 7));
  endtask

  task automatic rand_reqs();
    do begin
      rd_req = 1'($urandom_range(0, 1));
      wr_req = N_WR'($urandom);
    end while (!rd_req && wr_req == '0);
    rand_payload();
  endtask

  // Arbitration rule applied to the request picture at decision time.
  task automatic predict(output int code, output logic [27:0] a, output logic [3:0] l);
    code = -1; a = '0; l = '0;
    if (rd_req && (m_streak < int'(RD_STREAK) || wr_req == '0)) begin
      code = 15; a = rd_addr; l = rd_len;
      if (m_streak < int'(RD_STREAK)) m_streak++;
    end else begin
      for (int k = 1; k <= int'(N_WR); k++) begin
        int p;
        p = (m_last + k) % int'(N_WR);
        if (code < 0 && wr_req[p]) code = p;
      end
      if (code >= 0) begin
        a = wr_addr[code*28 +: 28];
        l = wr_len[code*4 +: 4];
        m_last = code;
        m_streak = 0;
      end
    end
  endtask

  task automatic post_grant(input int mode);
    if (mode == 1) rand_reqs();
    else if (mode == 2) begin
      wr_req = '0;
      rd_req = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string t);
    check({t, "_wr_grant"}, wr_grant, 0);
    check({t, "_wr_take"}, wr_take, 0);
    check({t, "_wr_done"}, wr_done, 0);
    check({t, "_rd_grant"}, rd_grant, 0);
    check({t, "_rd_valid"}, rd_valid, 0);
    check({t, "_rd_last"}, rd_last, 0);
    check({t, "_rd_data"}, rd_data, 0);
    check({t, "_awaddr"}, axi_awaddr, 0);
    check({t, "_awlen"}, axi_awlen, 0);
    check({t, "_awuser_id"}, axi_awuser_id, 0);
    check({t, "_awuser_ap"}, axi_awuser_ap, 0);
    check({t, "_awvalid"}, axi_awvalid, 0);
    check({t, "_wdata"}, axi_wdata, 0);
    check({t, "_wstrb"}, axi_wstrb, 32'hFFFF_FFFF);
    check({t, "_araddr"}, axi_araddr, 0);
    check({t, "_arlen"}, axi_arlen, 0);
    check({t, "_aruser_ap"}, axi_aruser_ap, 0);
    check({t, "_aruser_id"}, axi_aruser_id, RD_ID);
    check({t, "_arvalid"}, axi_arvalid, 0);
    check({t, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    axi_awready = 0; axi_wready = 0; axi_wusero_last = 0;
    axi_arready = 0; axi_rvalid = 0; axi_rlast = 0;
    wr_req = '0; rd_req = 0;
    rstn = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1;
    m_streak = 0;
    m_last = int'(N_WR) - 1;
  endtask

  // Called before the decision edge with requests set; returns after the
  // idle cycle that follows the burst has been sampled.
  task automatic run_tx(input int aw_wait, input int mode, output int code);
    int exp_code, w, beats, cnt;
    logic [27:0] ea;
    logic [3:0] el;
    logic [N_WR-1:0] sel;
    logic prev_rv, prev_last, done;
    logic [255:0] prev_rd;
    predict(exp_code, ea, el);
    w = (aw_wait < 0) ? $urandom_range(0, 3) : aw_wait;
    tick();
    check("wr_done_idle", wr_done, 0);
    check("rd_valid_idle", rd_valid, 0);
    code = (axi_arvalid && !axi_awvalid) ? 15 :
           ((axi_awvalid && !axi_arvalid) ? int'(axi_awuser_id) : -1);
    check("grant_kind", code, exp_code);
    done = 0; beats = 0; cnt = 0;
    if (exp_code == 15) begin
      for (int c = 0; c <= w && !done; c++) begin
        axi_arready = (c == w);
        settle();
        check("arvalid", axi_arvalid, 1);
        check("araddr", axi_araddr, ea);
        check("arlen", axi_arlen, el);
        check("aruser_id", axi_aruser_id, RD_ID);
        check("awvalid_in_rd", axi_awvalid, 0);
        check("busy_ar", busy, 1);
        check("rd_grant", rd_grant, axi_arready);
        if (axi_arready) begin done = 1; post_grant(mode); end
        tick();
      end
      axi_arready = 0;
      prev_rv = 0; prev_last = 0; prev_rd = '0; done = 0;
      for (int c = 0; c < 80 && !done; c++) begin
        axi_rvalid = ($urandom_range(0, 3) != 0);
        axi_rlast  = axi_rvalid && (beats == int'(el));
        axi_rdata  = rand256();
        settle();
        check("rd_valid", rd_valid, prev_rv);
        if (rd_valid) cnt++;
        if (prev_rv) begin
          check("rd_data", rd_data, prev_rd);
          check("rd_last", rd_last, prev_last);
        end
        check("busy_r", busy, 1);
        check("arvalid_r", axi_arvalid, 0);
        prev_rv = axi_rvalid; prev_rd = axi_rdata; prev_last = axi_rlast;
        if (axi_rvalid) begin
          beats++;
          if (axi_rlast) done = 1;
        end
        tick();
      end
      axi_rvalid = 0; axi_rlast = 0;
      settle();
      check("rd_valid_final", rd_valid, 1);
      check("rd_data_final", rd_data, prev_rd);
      check("rd_last_final", rd_last, 1);
      if (rd_valid) cnt++;
      check("rd_beat_count", cnt, int'(el) + 1);
      check("busy_after_rd", busy, 0);
    end else if (exp_code >= 0) begin
      sel = N_WR'(1) << exp_code;
      for (int c = 0; c <= w && !done; c++) begin
        axi_awready = (c == w);
        settle();
        check("awvalid", axi_awvalid, 1);
        check("awaddr", axi_awaddr, ea);
        check("awlen", axi_awlen, el);
        check("awuser_id", axi_awuser_id, exp_code);
        check("arvalid_in_wr", axi_arvalid, 0);
        check("busy_aw", busy, 1);
        check("wr_grant", wr_grant, axi_awready ? sel : '0);
        if (axi_awready) begin done = 1; post_grant(mode); end
        tick();
      end
      axi_awready = 0;
      done = 0;
      for (int c = 0; c < 80 && !done; c++) begin
        axi_wready = ($urandom_range(0, 3) != 0);
        axi_wusero_last = axi_wready && (beats == int'(el));
        for (int i = 0; i < N_WR; i++) wr_data[i*256 +: 256] = rand256();
        settle();
        check("wr_take", wr_take, axi_wready ? sel : '0);
        check("wdata", axi_wdata, wr_data[exp_code*256 +: 256]);
        check("busy_w", busy, 1);
        check("wr_done_mid", wr_done, 0);
        if (wr_take[exp_code]) cnt++;
        if (axi_wready) begin
          beats++;
          if (axi_wusero_last) done = 1;
        end
        tick();
      end
      axi_wready = 0; axi_wusero_last = 0;
      settle();
      check("wr_done", wr_done, sel);
      check("wr_take_count", cnt, int'(el) + 1);
      check("busy_after_wr", busy, 0);
      check("wr_take_idle", wr_take, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int code;
    int seq [11] = '{15, 15, 15, 15, 0, 15, 15, 15, 15, 1, 15};

    // Reset values, with live data on the inputs.
    rand_payload();
    wr_req = '0;
    axi_wready = 1;
    #3;
    check_reset_outputs("rst");
    do_reset();
    #1;
    check_reset_outputs("rst_rel");

    // Single write on port 1, length 4, awready already high.
    wr_req = 2'b10; rd_req = 0;
    wr_addr[28 +: 28] = 28'h0ABCDE0;
    wr_len[4 +: 4] = 4'd3;
    run_tx(0, 2, code);
    check("single_wr_port", code, 1);

    // Read at 0x1000, length 8, arready after 5 cycles.
    rd_req = 1; wr_req = '0;
    rd_addr = 28'h0001000; rd_len = 4'd7;
    run_tx(5, 2, code);
    check("single_rd", code, 15);

    // Read streak bound with everything requesting.
    do_reset();
    rd_req = 1; wr_req = 2'b11;
    rand_payload();
    for (int i = 0; i < 11; i++) begin
      run_tx(-1, 0, code);
      check("streak_order", code, seq[i]);
    end

    // Writers only: strict alternation.
    rd_req = 0; wr_req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      run_tx(-1, 0, code);
      check("wr_alternate", code, i % 2);
    end

    // Reset during beat 2 of a port-0 write; port 0 must win again afterwards.
    do_reset();
    wr_req = 2'b01;
    tick();
    axi_awready = 1;
    settle();
    check("mr_grant", wr_grant, 2'b01);
    tick();
    axi_awready = 0; axi_wready = 1;
    tick();
    settle();
    check("mr_take_beat2", wr_take, 2'b01);
    rstn = 0;
    #1;
    check_reset_outputs("midrst");
    axi_wready = 0;
    @(negedge clk);
    rstn = 1;
    m_streak = 0;
    m_last = int'(N_WR) - 1;
    wr_req = 2'b11;
    rand_payload();
    run_tx(-1, 0, code);
    check("after_reset_port0", code, 0);

    // Request dropped right after grant: burst still completes.
    rd_req = 0; wr_req = 2'b01;
    run_tx(-1, 2, code);
    check("drop_port", code, 1 - 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_no_req", busy, 0);
      check("idle_no_aw", axi_awvalid, 0);
    end

    // Randomized traffic.
    rand_reqs();
    for (int i = 0; i < 40; i++) run_tx(-1, 1, code);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
